top_stream_decoder: RTL and testbench
=====================================

// Module: top_stream_decoder
// PURPOSE
//  Receive-side inverse of the combinational top encoder: accepts 20-bit encoded words on a
//  valid/ready stream and recovers the 3-bit symbol. Encoder map: enc(x) = ((x ^ 3'd6) - 1) mod 2^20,
//  so legal codes are 20'hFFFFF and 20'h00000..20'h00006. Flags illegal words, keeps saturating
//  statistics, and locks out input after a burst of consecutive illegal words.
// PARAMETERS
//  DATA_W     20  encoded word width
//  SYM_W      3   decoded symbol width
//  XOR_KEY    6   encoder XOR constant (SYM_W bits)
//  CNT_W      16  width of statistics counters
//  ERR_LIMIT  4   consecutive illegal words that force FAULT (>=1)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       asynchronous, active-high reset
//  in_valid       in   1       input word valid
//  in_ready       out  1       block accepts input_data this cycle
//  input_data     in   DATA_W  encoded word
//  out_valid      out  1       decoded result valid
//  out_ready      in   1       downstream accepts result
//  output_data    out  SYM_W   decoded symbol (0 when out_err)
//  out_err        out  1       word was not a legal code
//  clear_counts   in   1       synchronous clear of counters and FAULT
//  fault          out  1       1 while in FAULT state
//  good_count     out  CNT_W   legal words delivered (saturating)
//  err_count      out  CNT_W   illegal words delivered (saturating)
// BEHAVIOUR
//  - Reset: out_valid=0, output_data=0, out_err=0, fault=0, counters=0, both stages empty, state RUN.
//  - Decode (combinational within stage 1): s = (input_data + 1) mod 2^DATA_W; legal iff s < 2^SYM_W;
//    symbol = s[SYM_W-1:0] ^ XOR_KEY; illegal -> symbol 0, err 1.
//  - Pipeline: 2 register stages (S1 decode, S2 output), each a valid/ready slice.
//    Latency 2 cycles from input handshake to out_valid with no stall; throughput 1 word/cycle.
//  - Slice rule: stage loads when empty or its contents leave the same cycle; ready upstream =
//    !valid_q || ready_downstream. Data/valid held stable while out_valid && !out_ready.
//  - in_ready = S1 slice ready && state==RUN. No word is dropped or duplicated under backpressure.
//  - Counters update on output handshake (out_valid && out_ready): good_count++ if !out_err,
//    else err_count++. Saturate at all-ones (no wrap).
//  - consec counter: ++ on illegal output handshake, cleared on legal output handshake.
//  - FSM: RUN -> FAULT when consec reaches ERR_LIMIT (transition on that handshake's edge).
//    FAULT: in_ready=0, fault=1, words already in S1/S2 drain normally and are still counted.
//    FAULT -> RUN on clear_counts.
//  - clear_counts: zeroes good_count, err_count, consec, returns to RUN; wins over a
//    simultaneous increment (result 0). Does not flush pipeline contents.
//  - rst asserted mid-transfer: pipeline contents discarded immediately, all outputs to reset values.
// STRUCTURE
//  - Package top_codec_pkg: DATA_W, SYM_W, XOR_KEY constants, state_e {RUN, FAULT},
//    functions enc_word() and dec_word() (returns {legal, symbol}) shared with encoder bench.
//  - Sub-module top_pipe_slice #(W): one valid/ready register stage, instanced for S1 and S2.
//  - Top holds decode logic, FSM, consec and statistics counters.
// TESTING
//  - Reset, then stream all 8 legal codes 20'h00005,6,3,4,1,2,FFFFF,00000 with out_ready=1 ->
//    symbols 0..7 in order, out_err=0, first out_valid 2 cycles after first accept, good_count=8.
//  - Illegal words 20'h00007 and 20'h80000 -> output_data=0, out_err=1, err_count=2, fault=0.
//  - out_ready=0 for 5 cycles during a 6-word burst -> in_ready drops after S1/S2 fill,
//    output sequence identical to input order, no loss, output stable while stalled.
//  - 4 consecutive illegal words -> fault=1, in_ready=0 after 4th delivery; a legal word
//    offered stays unaccepted; clear_counts -> fault=0, counters 0, word then accepted.
//  - clear_counts in same cycle as an output handshake -> counters read 0 next cycle.
//  - Force counters near max (CNT_W=4 build): 17 legal words -> good_count holds 4'hF.
//  - Assert rst with 2 words in flight -> out_valid=0 immediately, no stale output after release.

Source files
------------

// File: rtl/top_codec_pkg.sv
// Shared constants, state type and encode/decode helpers for the top codec
// (used by both the encoder and decoder sides).
package top_codec_pkg;

  localparam int unsigned DATA_W = 20;
  localparam int unsigned SYM_W  = 3;
  localparam logic [SYM_W-1:0] XOR_KEY = SYM_W'(6);

  typedef enum logic [0:0] {RUN, FAULT} state_e;

  function automatic logic [DATA_W-1:0] enc_word(input logic [SYM_W-1:0] sym);
    logic [DATA_W-1:0] x;
    x = DATA_W'(sym ^ XOR_KEY);
    return x - DATA_W'(1);
  endfunction

  // Returns {legal, symbol}; symbol is forced to 0 for illegal words.
  function automatic logic [SYM_W:0] dec_word(input logic [DATA_W-1:0] word);
    logic [DATA_W-1:0] s;
    logic              legal;
    logic [SYM_W-1:0]  sym;
    s     = word + DATA_W'(1);
    legal = (s[DATA_W-1:SYM_W] == '0);
    sym   = legal ? (s[SYM_W-1:0] ^ XOR_KEY) : SYM_W'(0);
    return {legal, sym};
  endfunction

endpackage

// File: rtl/top_pipe_slice.sv
// One valid/ready register stage: loads when empty or when its contents leave
// the same cycle, holds data stable while stalled.
module top_pipe_slice #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/top_stream_decoder.sv
// Stream decoder: two-stage valid/ready pipeline recovering symbols from encoded
// words, with saturating statistics and a lockout after a burst of illegal words.
module top_stream_decoder
  import top_codec_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ERR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] input_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  output_data,
  output logic              out_err,
  input  logic              clear_counts,
  output logic              fault,
  output logic [CNT_W-1:0]  good_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned S_W      = SYM_W + 1;
  localparam int unsigned CONSEC_W = $clog2(ERR_LIMIT + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(ERR_LIMIT);

  state_e              state_q, state_d;
  logic                run_en;
  logic [S_W-1:0]      dec, s1_in_data, s1_data, s2_data;
  logic                s1_in_valid, s1_ready, s1_valid, s2_ready;
  logic                out_hs;
  logic [CNT_W-1:0]    good_q, good_d, err_q, err_d;
  logic [CONSEC_W-1:0] consec_q, consec_d;

  // Stages carry {err, symbol}.
  assign dec         = dec_word(input_data);
  assign s1_in_data  = {~dec[SYM_W], dec[SYM_W-1:0]};
  assign s1_in_valid = in_valid && run_en;
  assign in_ready    = s1_ready && run_en;

  top_pipe_slice #(.W(S_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  top_pipe_slice #(.W(S_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign {out_err, output_data} = s2_data;
  assign out_hs = out_valid && out_ready;

  // Clear wins over any increment in the same cycle.
  always_comb begin
    good_d   = good_q;
    err_d    = err_q;
    consec_d = consec_q;
    if (clear_counts) begin
      good_d   = '0;
      err_d    = '0;
      consec_d = '0;
    end else if (out_hs) begin
      if (out_err) begin
        if (err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
        if (consec_q != CONSEC_MAX) consec_d = consec_q + CONSEC_W'(1);
      end else begin
        if (good_q != CNT_MAX) good_d = good_q + CNT_W'(1);
        consec_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_q   <= '0;
      err_q    <= '0;
      consec_q <= '0;
    end else begin
      good_q   <= good_d;
      err_q    <= err_d;
      consec_q <= consec_d;
    end
  end

  assign good_count = good_q;
  assign err_count  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (consec_d == CONSEC_MAX) state_d = FAULT;
      FAULT: if (clear_counts) state_d = RUN;
    endcase
  end

  always_comb begin
    run_en = (state_q == RUN);
    fault  = (state_q == FAULT);
  end

endmodule

// File: tb/tb_top_stream_decoder.sv
// Bench for top_stream_decoder: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations (16-bit and 4-bit counter builds).
module tb_top_stream_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, out_ready, clear_counts;
  logic [19:0] input_data;

  logic        in_ready, out_valid, out_err, fault;
  logic [2:0]  output_data;
  logic [15:0] good_count, err_count;
  logic        in_ready4, out_valid4, out_err4, fault4;
  logic [2:0]  output_data4;
  logic [3:0]  good_count4, err_count4;

  top_stream_decoder #(.CNT_W(16), .ERR_LIMIT(4)) dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
    .input_data (input_data), .out_valid (out_valid), .out_ready (out_ready),
    .output_data (output_data), .out_err (out_err), .clear_counts (clear_counts),
    .fault (fault), .good_count (good_count), .err_count (err_count)
  );

  top_stream_decoder #(.CNT_W(4), .ERR_LIMIT(4)) dut4 (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready4),
    .input_data (input_data), .out_valid (out_valid4), .out_ready (out_ready),
    .output_data (output_data4), .out_err (out_err4), .clear_counts (clear_counts),
    .fault (fault4), .good_count (good_count4), .err_count (err_count4)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [2:0] sym;
    logic       err;
    int         vis;
  } item_t;

  item_t      mq[$];
  logic [2:0] got_sym[$];
  logic       got_err[$];
  int         got_t[$];
  int         acc_t[$];
  int         n = 0;
  int         m_good = 0, m_err = 0, m_consec = 0;
  bit         m_fault = 0;
  int         errors = 0, checks = 0;

  logic [19:0] legal_codes[8] = '{20'h00005, 20'h00006, 20'h00003, 20'h00004,
                                  20'h00001, 20'h00002, 20'hFFFFF, 20'h00000};
  logic [19:0] stall_codes[6] = '{20'h00004, 20'h00006, 20'h00001, 20'hFFFFF,
                                  20'h00002, 20'h00000};
  logic [2:0]  stall_syms[6]  = '{3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7};
  logic [19:0] bad_codes[4]   = '{20'h00007, 20'h00008, 20'h80000, 20'h12345};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Decode straight from the code table: word w is legal iff w+1 (mod 2^20) < 8.
  function automatic item_t model_dec(input logic [19:0] w, input int vis);
    item_t it;
    int    s;
    s      = (int'(w) + 1) % (1 << 20);
    it.err = (s >= 8);
    it.sym = it.err ? 3'd0 : 3'(s ^ 6);
    it.vis = vis;
    return it;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    item_t it;
    logic  exp_ov, exp_ir;
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_valid4", 32'(out_valid4), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_good", 32'(good_count), 0);
      chk("rst_err", 32'(err_count), 0);
      mq.delete();
      m_good = 0; m_err = 0; m_consec = 0; m_fault = 0;
    end else begin
      exp_ov = (mq.size() > 0) && (n >= mq[0].vis);
      exp_ir = !m_fault && (mq.size() < 2 || out_ready);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("out_valid4", 32'(out_valid4), 32'(exp_ov));
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("in_ready4", 32'(in_ready4), 32'(exp_ir));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("fault4", 32'(fault4), 32'(m_fault));
      chk("good_count", 32'(good_count), sat(m_good, 16));
      chk("err_count", 32'(err_count), sat(m_err, 16));
      chk("good_count4", 32'(good_count4), sat(m_good, 4));
      chk("err_count4", 32'(err_count4), sat(m_err, 4));
      if (exp_ov) begin
        chk("output_data", 32'(output_data), 32'(mq[0].sym));
        chk("out_err", 32'(out_err), 32'(mq[0].err));
        chk("output_data4", 32'(output_data4), 32'(mq[0].sym));
      end
      if (exp_ov && out_ready) begin
        it = mq.pop_front();
        got_sym.push_back(output_data);
        got_err.push_back(out_err);
        got_t.push_back(n);
        if (it.err) begin
          m_err++;
          m_consec++;
        end else begin
          m_good++;
          m_consec = 0;
        end
        if (mq.size() > 0 && mq[0].vis < n + 1) mq[0].vis = n + 1;
      end
      if (in_valid && exp_ir) begin
        mq.push_back(model_dec(input_data, n + 2));
        acc_t.push_back(n);
      end
      if (clear_counts) begin
        m_good = 0; m_err = 0; m_consec = 0; m_fault = 0;
      end else if (!m_fault && m_consec >= 4) begin
        m_fault = 1;
      end
    end
    n++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] w);
    bit acc;
    acc = 0;
    in_valid   = 1'b1;
    input_data = w;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: word %05h not accepted within 50 cycles", w);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (mq.size() != 0 && k < 100) begin
      step();
      k++;
    end
    chk("drain_done", 32'(mq.size()), 0);
    repeat (2) step();
  endtask

  task automatic reset_logs();
    got_sym.delete();
    got_err.delete();
    got_t.delete();
    acc_t.delete();
  endtask

  task automatic pulse_clear();
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; input_data = '0; out_ready = 1'b1; clear_counts = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_output_data", 32'(output_data), 0);
    chk("reset_out_err", 32'(out_err), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    // All eight legal codes, no backpressure.
    reset_logs();
    for (int i = 0; i < 8; i++) send(legal_codes[i]);
    drain();
    chk("legal_count", 32'(got_sym.size()), 8);
    for (int i = 0; i < 8; i++) begin
      chk("legal_sym", 32'(got_sym[i]), i);
      chk("legal_err", 32'(got_err[i]), 0);
    end
    chk("latency", got_t[0] - acc_t[0], 2);
    chk("good_after_legal", 32'(good_count), 8);

    // Two illegal words.
    reset_logs();
    send(20'h00007);
    send(20'h80000);
    drain();
    chk("illegal_sym0", 32'(got_sym[0]), 0);
    chk("illegal_err0", 32'(got_err[0]), 1);
    chk("illegal_sym1", 32'(got_sym[1]), 0);
    chk("illegal_err1", 32'(got_err[1]), 1);
    chk("err_after_illegal", 32'(err_count), 2);
    chk("fault_after_illegal", 32'(fault), 0);

    // Six-word burst with a five-cycle output stall.
    reset_logs();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(stall_codes[i]);
      end
      begin
        repeat (3) step();
        chk("stall_in_ready_low", 32'(in_ready), 0);
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_hold_data", 32'(output_data), 3);
        repeat (2) step();
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", 32'(got_sym.size()), 6);
    for (int i = 0; i < 6; i++) chk("stall_order", 32'(got_sym[i]), 32'(stall_syms[i]));

    // Four consecutive illegal words force the lockout.
    reset_logs();
    for (int i = 0; i < 4; i++) send(bad_codes[i]);
    drain();
    chk("fault_set", 32'(fault), 1);
    chk("fault_in_ready", 32'(in_ready), 0);
    chk("fault_err_count", 32'(err_count), 6);
    in_valid = 1'b1; input_data = 20'h00005;
    repeat (4) step();
    chk("fault_blocks_input", 32'(in_ready), 0);
    chk("fault_no_output", 32'(got_sym.size()), 4);
    pulse_clear();
    chk("clear_fault", 32'(fault), 0);
    chk("clear_good", 32'(good_count), 0);
    chk("clear_err", 32'(err_count), 0);
    step();
    in_valid = 1'b0;
    drain();
    chk("post_clear_count", 32'(got_sym.size()), 5);
    chk("post_clear_sym", 32'(got_sym[4]), 0);
    chk("post_clear_good", 32'(good_count), 1);

    // Clear coinciding with an output handshake.
    send(20'h00006);
    step();
    chk("clear_hs_valid", 32'(out_valid), 1);
    pulse_clear();
    chk("clear_hs_good", 32'(good_count), 0);
    drain();
    chk("clear_hs_good_late", 32'(good_count), 0);

    // Saturation: 17 legal words.
    pulse_clear();
    for (int i = 0; i < 17; i++) send(legal_codes[i % 8]);
    drain();
    chk("sat_good4", 32'(good_count4), 15);
    chk("sat_good16", 32'(good_count), 17);

    // Reset with two words in flight.
    send(20'h00001);
    send(20'h00002);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 0);
    chk("rst_async_good", 32'(good_count), 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    reset_logs();
    repeat (6) step();
    chk("rst_no_stale", 32'(got_sym.size()), 0);
    chk("rst_idle_valid", 32'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
